bsg_cgol_host_ctrl: RTL and testbench

- Host-side initiator for the CGOL accelerator control channel.
- Accepts job descriptors (initial board plus frame count) from the testbench or SoC side.
- Issues each job over the controller's ready/valid input channel, waits for the controller's valid/yumi result, captures the final board from the cell array and returns it on a result channel.
- One job in flight at a time; sits between the job source and the controller/cell array pair.

---
 rtl/bsg_cgol_host_ctrl_if.sv | 45 ++++
 rtl/bsg_cgol_host_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bsg_cgol_host_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_cgol_host_ctrl_if.sv
// Channel bundle between the host controller, the job source, the CGOL controller/cell array and the result consumer.
// Latency: none, wires only.
// Backpressure: carries job ready/valid, controller ready/valid and valid/yumi, and result valid/yumi handshakes.
interface bsg_cgol_host_ctrl_if #(
    parameter int max_game_length_p = 1024,
    parameter int board_width_p     = 8
);
    localparam int game_len_width_lp = (max_game_length_p + 1 > 1) ? $clog2(max_game_length_p + 1) : 1;
    localparam int board_bits_lp     = board_width_p * board_width_p;

    // job source side
    logic [game_len_width_lp-1:0] job_frames_i;
    logic [board_bits_lp-1:0]     job_board_i;
    logic                         job_v_i;
    logic                         job_ready_o;
    // controller / cell array side
    logic [game_len_width_lp-1:0] frames_o;
    logic [board_bits_lp-1:0]     board_o;
    logic                         v_o;
    logic                         ready_i;
    logic                         v_i;
    logic [board_bits_lp-1:0]     board_i;
    logic                         yumi_o;
    // result side
    logic [board_bits_lp-1:0]     result_board_o;
    logic [game_len_width_lp-1:0] result_frames_o;
    logic                         result_err_o;
    logic                         result_v_o;
    logic                         result_yumi_i;
    logic [15:0]                  games_done_o;

    // view of the host controller itself
    modport slave (
        input  job_frames_i, job_board_i, job_v_i, ready_i, v_i, board_i, result_yumi_i,
        output job_ready_o, frames_o, board_o, v_o, yumi_o,
               result_board_o, result_frames_o, result_err_o, result_v_o, games_done_o
    );

    // view of the surrounding environment driving the controller
    modport master (
        output job_frames_i, job_board_i, job_v_i, ready_i, v_i, board_i, result_yumi_i,
        input  job_ready_o, frames_o, board_o, v_o, yumi_o,
               result_board_o, result_frames_o, result_err_o, result_v_o, games_done_o
    );
endinterface

// File: rtl/bsg_cgol_host_ctrl.sv
// Host-side initiator: takes one CGOL job, runs it on the controller, returns the final board.
// Latency: job accept -> v_o 1 cycle; controller v_i -> result_v_o 1 cycle; one job in flight.
// Backpressure: job_ready_o only in IDLE; v_o held until ready_i; result held until result_yumi_i.
// Optional watchdog + terminal FAULT state enabled by defining BSG_CGOL_HOST_TIMEOUT_EN.
module bsg_cgol_host_ctrl #(
    parameter int max_game_length_p = 1024,
    parameter int board_width_p     = 8,
    parameter int timeout_cycles_p  = 4096
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_cgol_host_ctrl_if.slave bus
);
    localparam int game_len_width_lp = (max_game_length_p + 1 > 1) ? $clog2(max_game_length_p + 1) : 1;
    localparam int board_bits_lp     = board_width_p * board_width_p;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    localparam logic [2:0] S_FAULT  = 3'd4;
    localparam int timer_width_lp   = (timeout_cycles_p + 1 > 1) ? $clog2(timeout_cycles_p + 1) : 1;
`else
    localparam int unused_timeout_lp = timeout_cycles_p;
`endif

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_n;
    logic [board_bits_lp-1:0]     r_board;
    logic [game_len_width_lp-1:0] r_frames;
    logic [board_bits_lp-1:0]     r_res_board;
    logic [game_len_width_lp-1:0] r_res_frames;
    logic [15:0]                  r_games_done;
    logic [game_len_width_lp-1:0] w_job_frames;
    logic                         w_accept;
    logic                         w_issue_hs;
    logic                         w_done;
    logic                         w_res_taken;
    logic                         w_timeout;
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    logic [timer_width_lp-1:0]    r_timer;
    logic                         r_res_err;
`endif

    // Requests longer than the controller supports are clamped rather than rejected.
    assign w_job_frames = (bus.job_frames_i > game_len_width_lp'(max_game_length_p))
                        ? game_len_width_lp'(max_game_length_p) : bus.job_frames_i;

    assign w_accept    = (r_state == S_IDLE)   & bus.job_v_i;
    assign w_issue_hs  = (r_state == S_ISSUE)  & bus.ready_i;
    assign w_done      = (r_state == S_WAIT)   & bus.v_i;
    assign w_res_taken = (r_state == S_RESULT) & bus.result_yumi_i;

`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    // Watchdog fires on the last permitted WAIT cycle when the controller stays silent.
    assign w_timeout = (r_state == S_WAIT) & ~bus.v_i
                     & (r_timer == timer_width_lp'(timeout_cycles_p - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state selection for the job sequencer.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.job_v_i) begin
                    // A 0-frame game cannot be terminated by the controller, so skip it.
                    w_state_n = (w_job_frames == '0) ? S_RESULT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.ready_i) w_state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.v_i || w_timeout) w_state_n = S_RESULT;
            end
            S_RESULT: begin
                if (bus.result_yumi_i) begin
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
                    w_state_n = r_res_err ? S_FAULT : S_IDLE;
`else
                    w_state_n = S_IDLE;
`endif
                end
            end
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
            S_FAULT: w_state_n = S_FAULT;
`endif
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_state_n;
    end

    // Latch the accepted job; board_o keeps showing it until the next job.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_board  <= '0;
            r_frames <= '0;
        end else if (w_accept) begin
            r_board  <= bus.job_board_i;
            r_frames <= w_job_frames;
        end
    end

    // Capture the result: input board for 0-frame jobs, cell array board on completion,
    // original board when the watchdog gives up.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_res_board  <= '0;
            r_res_frames <= '0;
        end else if (w_accept && (w_job_frames == '0)) begin
            r_res_board  <= bus.job_board_i;
            r_res_frames <= '0;
        end else if (w_done) begin
            r_res_board  <= bus.board_i;
            r_res_frames <= r_frames;
        end else if (w_timeout) begin
            r_res_board  <= r_board;
            r_res_frames <= r_frames;
        end
    end

`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    // Error flag tracks whether the current result came from the watchdog.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                                 r_res_err <= 1'b0;
        else if (w_accept && (w_job_frames == '0))   r_res_err <= 1'b0;
        else if (w_done)                             r_res_err <= 1'b0;
        else if (w_timeout)                          r_res_err <= 1'b1;
    end

    // WAIT-cycle counter, restarted on every issue handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                 r_timer <= '0;
        else if (w_issue_hs)         r_timer <= '0;
        else if (r_state == S_WAIT)  r_timer <= r_timer + 1'b1;
    end
`endif

    // Completed-result counter, including error results; wraps naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)          r_games_done <= '0;
        else if (w_res_taken) r_games_done <= r_games_done + 16'd1;
    end

    assign bus.job_ready_o     = (r_state == S_IDLE);
    assign bus.v_o             = (r_state == S_ISSUE);
    assign bus.frames_o        = r_frames;
    assign bus.board_o         = r_board;
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    // Stray completions in FAULT are drained so the controller never wedges.
    assign bus.yumi_o          = bus.v_i & ((r_state == S_WAIT) | (r_state == S_FAULT));
    assign bus.result_err_o    = r_res_err;
`else
    assign bus.yumi_o          = w_done;
    assign bus.result_err_o    = 1'b0;
`endif
    assign bus.result_v_o      = (r_state == S_RESULT);
    assign bus.result_board_o  = r_res_board;
    assign bus.result_frames_o = r_res_frames;
    assign bus.games_done_o    = r_games_done;
endmodule

// File: tb/tb_bsg_cgol_host_ctrl.sv
// Bench for the CGOL host controller: controller stub and result consumer driven from tasks,
// expected results derived from the job rules (clamp, 0-frame bypass, one game per result).
// Define BSG_CGOL_HOST_TIMEOUT_EN to also exercise the watchdog with a 16-cycle limit.
module tb_bsg_cgol_host_ctrl;
    localparam int MAX = 1024;
    localparam int BW  = 8;
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    localparam int TO  = 16;
`else
    localparam int TO  = 4096;
`endif
    localparam int FW  = $clog2(MAX + 1);
    localparam int BB  = BW * BW;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    bsg_cgol_host_ctrl_if #(.max_game_length_p(MAX), .board_width_p(BW)) bus ();

    bsg_cgol_host_ctrl #(
        .max_game_length_p(MAX),
        .board_width_p    (BW),
        .timeout_cycles_p (TO)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_games = 0;
    logic [159:0] got, want;

    function automatic logic [BB-1:0] rnd_board();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        bus.job_frames_i  = '0;
        bus.job_board_i   = '0;
        bus.job_v_i       = 1'b0;
        bus.ready_i       = 1'b0;
        bus.v_i           = 1'b0;
        bus.board_i       = '0;
        bus.result_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1'b1;
        #12;
        got  = 160'({bus.job_ready_o, bus.v_o, bus.yumi_o, bus.result_v_o, bus.result_err_o,
                     bus.games_done_o, bus.frames_o, bus.board_o, bus.result_frames_o});
        want = 160'({5'b10000, 16'd0, FW'(0), BB'(0), FW'(0)});
        total++;
        if (got !== want) begin bad++; $display("FAIL reset_state: got %h want %h", got, want); end
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        exp_games = 0;
    endtask

    // One complete job: issue with rdy_dly stalled cycles, controller finishes after
    // done_dly WAIT cycles returning fin, consumer stalls yumi_dly cycles.
    task automatic drive_job(input logic [FW-1:0] f, input logic [BB-1:0] b, input int rdy_dly,
                             input int done_dly, input int yumi_dly, input logic [BB-1:0] fin);
        logic [FW-1:0] ef;
        logic [BB-1:0] eb;
        ef = (f > FW'(MAX)) ? FW'(MAX) : f;
        eb = (ef == '0) ? b : fin;

        total++;
        if (bus.job_ready_o !== 1'b1) begin bad++; $display("FAIL job_ready_idle: got %b want 1", bus.job_ready_o); end
        bus.job_v_i = 1'b1; bus.job_frames_i = f; bus.job_board_i = b;
        @(posedge clk_i); #1;
        bus.job_v_i = 1'b0; bus.job_frames_i = FW'($urandom); bus.job_board_i = rnd_board();

        if (ef != '0) begin
            bus.ready_i = 1'b0;
            for (int i = 0; i <= rdy_dly; i++) begin
                if (i == rdy_dly) bus.ready_i = 1'b1;
                bus.v_i = 1'(($urandom % 2)); #1;
                got  = 160'({bus.v_o, bus.yumi_o, bus.job_ready_o, bus.result_v_o, bus.frames_o, bus.board_o});
                want = 160'({4'b1000, ef, b});
                total++;
                if (got !== want) begin bad++; $display("FAIL issue_hold: got %h want %h", got, want); end
                @(posedge clk_i); #1;
            end
            bus.ready_i = 1'b0;
            bus.v_i = 1'b0;
            for (int i = 0; i < done_dly; i++) begin
                bus.board_i = rnd_board(); #1;
                got  = 160'({bus.v_o, bus.yumi_o, bus.job_ready_o, bus.result_v_o, bus.board_o});
                want = 160'({4'b0000, b});
                total++;
                if (got !== want) begin bad++; $display("FAIL wait_idle: got %h want %h", got, want); end
                @(posedge clk_i); #1;
            end
            bus.v_i = 1'b1; bus.board_i = fin; #1;
            got  = 160'({bus.v_o, bus.yumi_o, bus.result_v_o});
            want = 160'(3'b010);
            total++;
            if (got !== want) begin bad++; $display("FAIL done_yumi: got %h want %h", got, want); end
            @(posedge clk_i); #1;
            bus.v_i = 1'b0; bus.board_i = rnd_board();
        end

        for (int i = 0; i <= yumi_dly; i++) begin
            bus.v_i = 1'(($urandom % 2));
            if (i == yumi_dly) bus.result_yumi_i = 1'b1;
            #1;
            got  = 160'({bus.result_v_o, bus.result_err_o, bus.job_ready_o, bus.v_o, bus.yumi_o,
                         bus.result_frames_o, bus.result_board_o, bus.games_done_o});
            want = 160'({5'b10000, ef, eb, 16'(exp_games)});
            total++;
            if (got !== want) begin bad++; $display("FAIL result_hold: got %h want %h", got, want); end
            @(posedge clk_i); #1;
        end
        bus.result_yumi_i = 1'b0; bus.v_i = 1'b0;
        exp_games++;
        got  = 160'({bus.job_ready_o, bus.result_v_o, bus.v_o, bus.games_done_o});
        want = 160'({3'b100, 16'(exp_games)});
        total++;
        if (got !== want) begin bad++; $display("FAIL after_yumi: got %h want %h", got, want); end
    endtask

    task automatic test_basic();
        drive_job(FW'(5), 64'h0000_0000_0020_1070, 0, 7, 0, rnd_board());
    endtask

    task automatic test_zero_frames();
        drive_job(FW'(0), 64'hFF, 0, 0, 0, rnd_board());
        drive_job(FW'(0), rnd_board(), 3, 0, 2, rnd_board());
    endtask

    task automatic test_backpressure();
        drive_job(FW'(9), rnd_board(), 10, 3, 6, rnd_board());
    endtask

    task automatic test_clamp();
        drive_job(FW'(MAX + 3), rnd_board(), 1, 2, 0, rnd_board());
        drive_job(FW'(2047), rnd_board(), 0, 0, 1, rnd_board());
        drive_job(FW'(MAX), rnd_board(), 0, 1, 0, rnd_board());
    endtask

    task automatic test_back_to_back();
        int start;
        start = exp_games;
        for (int k = 0; k < 3; k++) drive_job(FW'(k + 1), rnd_board(), 0, 0, 0, rnd_board());
        total++;
        if (bus.games_done_o !== 16'(start + 3)) begin
            bad++; $display("FAIL back_to_back_count: got %0d want %0d", bus.games_done_o, start + 3);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            drive_job(FW'($urandom_range(0, 2047)), rnd_board(), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), rnd_board());
        end
    endtask

    task automatic test_reset_mid_wait();
        bus.job_v_i = 1'b1; bus.job_frames_i = FW'(4); bus.job_board_i = rnd_board(); bus.ready_i = 1'b1;
        @(posedge clk_i); #1;
        bus.job_v_i = 1'b0;
        @(posedge clk_i); #1;
        bus.ready_i = 1'b0;
        @(posedge clk_i); #2;
        reset_i = 1'b1; #1;
        got  = 160'({bus.job_ready_o, bus.v_o, bus.yumi_o, bus.result_v_o, bus.result_err_o,
                     bus.games_done_o, bus.board_o, bus.frames_o});
        want = 160'({5'b10000, 16'd0, BB'(0), FW'(0)});
        total++;
        if (got !== want) begin bad++; $display("FAIL reset_mid_wait: got %h want %h", got, want); end
        exp_games = 0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        bus.v_i = 1'b1; bus.board_i = rnd_board(); #1;
        got  = 160'({bus.yumi_o, bus.job_ready_o, bus.v_o});
        want = 160'(3'b010);
        total++;
        if (got !== want) begin bad++; $display("FAIL stray_v_after_reset: got %h want %h", got, want); end
        @(posedge clk_i); #1;
        bus.v_i = 1'b0;
        total++;
        if (bus.result_v_o !== 1'b0) begin bad++; $display("FAIL stray_v_no_result: got %b want 0", bus.result_v_o); end
        drive_job(FW'(2), rnd_board(), 0, 1, 0, rnd_board());
    endtask

`ifdef BSG_CGOL_HOST_TIMEOUT_EN
    task automatic test_timeout();
        logic [BB-1:0] b;
        b = rnd_board();
        bus.job_v_i = 1'b1; bus.job_frames_i = FW'(3); bus.job_board_i = b; bus.ready_i = 1'b1;
        @(posedge clk_i); #1;
        bus.job_v_i = 1'b0;
        @(posedge clk_i); #1;
        bus.ready_i = 1'b0;
        repeat (TO - 1) @(posedge clk_i);
        #1;
        total++;
        if (bus.result_v_o !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", bus.result_v_o); end
        @(posedge clk_i); #1;
        got  = 160'({bus.result_v_o, bus.result_err_o, bus.result_frames_o, bus.result_board_o});
        want = 160'({2'b11, FW'(3), b});
        total++;
        if (got !== want) begin bad++; $display("FAIL timeout_result: got %h want %h", got, want); end
        bus.result_yumi_i = 1'b1;
        @(posedge clk_i); #1;
        bus.result_yumi_i = 1'b0;
        exp_games++;
        bus.v_i = 1'b1; bus.job_v_i = 1'b1; bus.job_frames_i = FW'(1); #1;
        got  = 160'({bus.job_ready_o, bus.v_o, bus.yumi_o, bus.result_v_o, bus.games_done_o});
        want = 160'({4'b0010, 16'(exp_games)});
        total++;
        if (got !== want) begin bad++; $display("FAIL fault_drain: got %h want %h", got, want); end
        @(posedge clk_i); #1;
        got  = 160'({bus.job_ready_o, bus.v_o, bus.result_v_o});
        want = 160'(3'b000);
        total++;
        if (got !== want) begin bad++; $display("FAIL fault_terminal: got %h want %h", got, want); end
        bus.v_i = 1'b0; bus.job_v_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_frames();
        test_backpressure();
        test_clamp();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
`ifdef BSG_CGOL_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
